// File: rtl/i2s_dac_tx.sv
// I2S DAC transmitter: holds one stereo pair and serializes it MSB-first
// with generated BCLK/LRCK and a per-frame sample trigger for the synthesizer.
module i2s_dac_tx #(
    parameter int AUD_BIT_DEPTH = 24,
    parameter int SLOT_BITS     = 32,
    parameter int BCLK_DIV      = 4
) (
    input  logic                     i_audio_clk,
    input  logic                     i_reset_data,
    input  logic [AUD_BIT_DEPTH-1:0] i_lsound_in,
    input  logic [AUD_BIT_DEPTH-1:0] i_rsound_in,
    input  logic                     i_sample_valid,
    input  logic                     i_underrun_clr,
    output logic                     o_aud_bclk,
    output logic                     o_aud_daclrck,
    output logic                     o_aud_dacdat,
    output logic                     o_frame_start,
    output logic                     o_underrun
);
    localparam int FRAME_BITS = 2 * SLOT_BITS;
    localparam int BIT_W      = $clog2(FRAME_BITS);
    localparam int DIV_W      = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
    localparam logic [BIT_W-1:0] K_LAST   = BIT_W'(FRAME_BITS - 1);
    localparam logic [BIT_W-1:0] K_L_END  = BIT_W'(AUD_BIT_DEPTH);
    localparam logic [BIT_W-1:0] K_R_SLOT = BIT_W'(SLOT_BITS);
    localparam logic [BIT_W-1:0] K_R_END  = BIT_W'(SLOT_BITS + AUD_BIT_DEPTH);

    logic [DIV_W-1:0]         r_div_cnt;
    logic [BIT_W-1:0]         r_bit_cnt;
    logic                     r_bclk;
    logic                     r_lrck;
    logic                     r_dat;
    logic                     r_frame_start;
    logic                     r_underrun;
    logic                     r_hold_full;
    logic [AUD_BIT_DEPTH-1:0] r_hold_l;
    logic [AUD_BIT_DEPTH-1:0] r_hold_r;
    logic [AUD_BIT_DEPTH-1:0] r_last_l;
    logic [AUD_BIT_DEPTH-1:0] r_last_r;
    logic [AUD_BIT_DEPTH-1:0] r_shift_l;
    logic [AUD_BIT_DEPTH-1:0] r_shift_r;

    logic                     w_div_wrap;
    logic                     w_fall;
    logic                     w_load;
    logic [BIT_W-1:0]         w_next_bit;
    logic [AUD_BIT_DEPTH-1:0] w_load_l;
    logic [AUD_BIT_DEPTH-1:0] w_load_r;

    assign w_div_wrap = (r_div_cnt == DIV_LAST);
    assign w_fall     = w_div_wrap && r_bclk;
    assign w_next_bit = (r_bit_cnt == K_LAST) ? '0 : r_bit_cnt + 1'b1;
    assign w_load     = w_fall && (w_next_bit == '0);

    // A strobe coinciding with the load bypasses the buffer; otherwise the
    // buffered pair is used, and with nothing buffered the last pair repeats.
    always_comb begin
        w_load_l = r_last_l;
        w_load_r = r_last_r;
        if (i_sample_valid) begin
            w_load_l = i_lsound_in;
            w_load_r = i_rsound_in;
        end else if (r_hold_full) begin
            w_load_l = r_hold_l;
            w_load_r = r_hold_r;
        end
    end

    always_ff @(posedge i_audio_clk) begin
        if (i_reset_data) begin
            r_div_cnt     <= '0;
            r_bit_cnt     <= K_LAST;
            r_bclk        <= 1'b0;
            r_lrck        <= 1'b1;
            r_dat         <= 1'b0;
            r_frame_start <= 1'b0;
            r_underrun    <= 1'b0;
            r_hold_full   <= 1'b0;
            r_hold_l      <= '0;
            r_hold_r      <= '0;
            r_last_l      <= '0;
            r_last_r      <= '0;
            r_shift_l     <= '0;
            r_shift_r     <= '0;
        end else begin
            r_frame_start <= 1'b0;
            r_div_cnt     <= w_div_wrap ? '0 : r_div_cnt + 1'b1;
            if (w_div_wrap) begin
                r_bclk <= ~r_bclk;
            end

            if (i_sample_valid) begin
                r_hold_l    <= i_lsound_in;
                r_hold_r    <= i_rsound_in;
                r_hold_full <= 1'b1;
            end

            if (i_underrun_clr) begin
                r_underrun <= 1'b0;
            end

            if (w_fall) begin
                r_bit_cnt <= w_next_bit;
                r_dat     <= 1'b0;
                if (w_load) begin
                    r_frame_start <= 1'b1;
                    r_lrck        <= 1'b0;
                    r_last_l      <= w_load_l;
                    r_last_r      <= w_load_r;
                    r_shift_l     <= w_load_l;
                    r_shift_r     <= w_load_r;
                    // Later assignments here take priority over the write and clear above.
                    if (i_sample_valid || r_hold_full) begin
                        r_hold_full <= 1'b0;
                    end else begin
                        r_underrun <= 1'b1;
                    end
                end else if (w_next_bit <= K_L_END) begin
                    r_dat     <= r_shift_l[AUD_BIT_DEPTH-1];
                    r_shift_l <= r_shift_l << 1;
                end else if (w_next_bit == K_R_SLOT) begin
                    r_lrck <= 1'b1;
                end else if ((w_next_bit > K_R_SLOT) && (w_next_bit <= K_R_END)) begin
                    r_dat     <= r_shift_r[AUD_BIT_DEPTH-1];
                    r_shift_r <= r_shift_r << 1;
                end
            end
        end
    end

    assign o_aud_bclk    = r_bclk;
    assign o_aud_daclrck = r_lrck;
    assign o_aud_dacdat  = r_dat;
    assign o_frame_start = r_frame_start;
    assign o_underrun    = r_underrun;

endmodule

// File: tb/tb_i2s_dac_tx.sv
// Bench for i2s_dac_tx: directed stimulus pushes expected frames into a queue;
// a monitor captures each serialized frame on BCLK rises and compares.
module tb_i2s_dac_tx;
    localparam int D        = 24;
    localparam int N_FRAMES = 8;

    typedef struct {
        logic [D-1:0] l;
        logic [D-1:0] r;
        logic         u_start;
        logic         u_mid;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [D-1:0] l_in = '0;
    logic [D-1:0] r_in = '0;
    logic         sv = 1'b0;
    logic         uclr = 1'b0;
    logic         bclk, lrck, dat, fs, und;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   mon_en = 1'b0;
    bit   mon_done = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    i2s_dac_tx #(.AUD_BIT_DEPTH(D), .SLOT_BITS(32), .BCLK_DIV(4)) dut (
        .i_audio_clk   (clk),
        .i_reset_data  (rst),
        .i_lsound_in   (l_in),
        .i_rsound_in   (r_in),
        .i_sample_valid(sv),
        .i_underrun_clr(uclr),
        .o_aud_bclk    (bclk),
        .o_aud_daclrck (lrck),
        .o_aud_dacdat  (dat),
        .o_frame_start (fs),
        .o_underrun    (und)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    task automatic push_exp(input logic [D-1:0] l, input logic [D-1:0] r,
                            input logic us, input logic um);
        exp_t e;
        e.l = l; e.r = r; e.u_start = us; e.u_mid = um;
        exp_q.push_back(e);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_fs(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (fs !== 1'b1 && n < 2000);
        if (fs !== 1'b1) fail({tag, "_frame_start"});
    endtask

    task automatic write_pair(input logic [D-1:0] l, input logic [D-1:0] r);
        l_in = l; r_in = r; sv = 1'b1;
        @(negedge clk);
        sv = 1'b0;
    endtask

    task automatic pulse_clr();
        uclr = 1'b1;
        @(negedge clk);
        uclr = 1'b0;
    endtask

    task automatic wait_bclk(input logic lvl, output bit ok);
        int n = 0;
        ok = 1'b1;
        while (bclk !== lvl) begin
            @(negedge clk);
            n++;
            if (n > 64) begin
                ok = 1'b0;
                return;
            end
        end
    endtask

    task automatic run_monitor();
        exp_t         e;
        int           t_prev = 0;
        int           n;
        bit           ok;
        logic [D-1:0] l_cap, r_cap;
        logic [63:0]  lr_bits;
        logic         pad, u_mid;
        for (int f = 0; f < N_FRAMES; f++) begin
            n = 0;
            while (fs !== 1'b1) begin
                @(negedge clk);
                n++;
                if (n > 2000) begin
                    fail($sformatf("frame%0d_start", f));
                    return;
                end
            end
            if (exp_q.size() == 0) begin
                fail($sformatf("frame%0d_no_expectation", f));
                return;
            end
            e = exp_q.pop_front();
            if (f > 0) check($sformatf("frame%0d_period", f), 64'(cyc - t_prev), 64'd512);
            t_prev = cyc;
            check($sformatf("frame%0d_underrun_start", f), 64'(und), 64'(e.u_start));
            l_cap = '0; r_cap = '0; lr_bits = '0; pad = 1'b0; u_mid = 1'b0;
            for (int i = 0; i < 64; i++) begin
                wait_bclk(1'b0, ok);
                if (ok) wait_bclk(1'b1, ok);
                if (!ok) begin
                    fail($sformatf("frame%0d_bclk_rise%0d", f, i));
                    return;
                end
                lr_bits[i] = lrck;
                if (i >= 1 && i <= 24)       l_cap = {l_cap[D-2:0], dat};
                else if (i >= 33 && i <= 56) r_cap = {r_cap[D-2:0], dat};
                else                         pad = pad | dat;
                if (i == 32) u_mid = und;
            end
            check($sformatf("frame%0d_left", f), 64'(l_cap), 64'(e.l));
            check($sformatf("frame%0d_right", f), 64'(r_cap), 64'(e.r));
            check($sformatf("frame%0d_padding", f), 64'(pad), 64'd0);
            check($sformatf("frame%0d_lrck", f), lr_bits, 64'hFFFF_FFFF_0000_0000);
            check($sformatf("frame%0d_underrun_mid", f), 64'(u_mid), 64'(e.u_mid));
        end
    endtask

    initial begin : monitor
        wait (mon_en);
        run_monitor();
        mon_done = 1'b1;
    end

    initial begin : stimulus
        int n;
        rst = 1'b1;
        cycles(4);
        rst = 1'b0;
        cycles(150);
        check("pre_reset_underrun", 64'(und), 64'd1);

        // mid-frame reset
        rst = 1'b1;
        cycles(1);
        check("reset_bclk", 64'(bclk), 64'd0);
        check("reset_lrck", 64'(lrck), 64'd1);
        check("reset_dat", 64'(dat), 64'd0);
        check("reset_frame_start", 64'(fs), 64'd0);
        check("reset_underrun", 64'(und), 64'd0);
        cycles(1);
        mon_en = 1'b1;
        rst = 1'b0;
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            n++;
            if (fs === 1'b1) break;
            if (n == 2) begin
                l_in = 24'hA5A5A5; r_in = 24'h5A5A5A; sv = 1'b1;
                push_exp(24'hA5A5A5, 24'h5A5A5A, 1'b0, 1'b0);
            end
            if (n == 3) sv = 1'b0;
        end
        check("first_frame_start_cycle", 64'(n), 64'd8);

        // two starved frames repeat the pair; clear during F2, set+clear at F3 load
        push_exp(24'hA5A5A5, 24'h5A5A5A, 1'b1, 1'b1);
        push_exp(24'hA5A5A5, 24'h5A5A5A, 1'b1, 1'b0);
        wait_fs("f1");
        wait_fs("f2");
        cycles(20);
        pulse_clr();
        push_exp(24'hA5A5A5, 24'h5A5A5A, 1'b1, 1'b1);
        cycles(490);
        uclr = 1'b1;
        cycles(1);
        uclr = 1'b0;

        // clear late in F3, then bypass write exactly on the F4 load cycle
        cycles(400);
        pulse_clr();
        push_exp(24'h000001, 24'hFFFFFE, 1'b0, 1'b0);
        push_exp(24'h000001, 24'hFFFFFE, 1'b1, 1'b0);
        cycles(110);
        write_pair(24'h000001, 24'hFFFFFE);

        // F5 underruns; clear it, then two writes where the latest wins
        wait_fs("f5");
        cycles(20);
        pulse_clr();
        cycles(80);
        write_pair(24'h111111, 24'h333333);
        cycles(100);
        write_pair(24'h222222, 24'h444444);
        push_exp(24'h222222, 24'h444444, 1'b0, 1'b0);

        // full-scale extremes
        wait_fs("f6");
        cycles(50);
        write_pair(24'h800000, 24'h7FFFFF);
        push_exp(24'h800000, 24'h7FFFFF, 1'b0, 1'b0);

        n = 0;
        while (!mon_done && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!mon_done) fail("monitor_done");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
